// File: rtl/alu_result_display.sv
// -----------------------------------------------------------------------------
// alu_result_display
//
// Purpose:
//   Consumes the ALU result bus. On a load strobe (sampled only in IDLE) it
//   latches the result, converts it to BCD with a sequential double-dabble
//   engine (one iteration per clock), then commits the digits to a display
//   register. That register drives a continuously scanned 4-digit, active-low
//   7-segment display.
//   In divide mode (func = 11) the upper and lower halves of the result bus
//   (quotient / remainder) are converted as two independent 2-digit fields and
//   shown without blanking. Otherwise the whole word is shown with leading-zero
//   blanking on digits 3..1.
//
// Parameters:
//   WIDTH    - ALU operand width (2..6); the result bus is 2*WIDTH bits.
//   SCAN_DIV - clock cycles each digit stays selected (>= 2).
//
// Ports:
//   clk   in   system clock, rising edge
//   rst   in   synchronous, active-high reset
//   load  in   capture strobe
//   value in   result word (divide: [2W-1:W] quotient, [W-1:0] remainder)
//   func  in   ALU function code (00 add, 01 sub, 10 mul, 11 div)
//   ovf   in   ALU overflow flag
//   busy  out  high while a conversion is in progress
//   seg   out  segments {g,f,e,d,c,b,a}, active-low
//   dp    out  decimal point, active-low
//   an    out  digit enables, active-low one-hot, an[3] = leftmost
//
// Build option:
//   ALU_RESULT_DISPLAY_OVF_EN - when defined, an add/sub overflow lights the
//   decimal point of digit 3. When undefined, ovf is ignored and dp stays 1.
// -----------------------------------------------------------------------------
module alu_result_display #(
  parameter int WIDTH    = 6,
  parameter int SCAN_DIV = 50000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [2*WIDTH-1:0] value,
  input  logic [1:0]         func,
  input  logic               ovf,
  output logic               busy,
  output logic [6:0]         seg,
  output logic               dp,
  output logic [3:0]         an
);

  localparam int RW = 2 * WIDTH;
  localparam int PW = $clog2(SCAN_DIV);

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  state_t         state_q, state_d;
  logic [RW-1:0]  shift_q, shift_d;
  logic [15:0]    bcd_q, bcd_d;
  logic           split_q, split_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [15:0]    disp_q, disp_d;
  logic           disp_split_q, disp_split_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic [1:0]     idx_q, idx_d;
  logic [3:0]     an_q, an_d;
  logic [6:0]     seg_q, seg_d;

  // Double-dabble correction: a nibble of 5 or more would reach 10+ after the
  // shift, so add 3 first to carry into the next decimal digit.
  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] seg_code(input logic [3:0] n);
    case (n)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  logic [15:0] bcd_adj;
  assign bcd_adj = {add3(bcd_q[15:12]), add3(bcd_q[11:8]),
                    add3(bcd_q[7:4]),   add3(bcd_q[3:0])};

`ifdef ALU_RESULT_DISPLAY_OVF_EN
  logic ovf_lat_q, ovf_lat_d;
  logic disp_ovf_q, disp_ovf_d;
  logic dp_q, dp_d;
`else
  // ovf has no function in this build.
  logic unused_ovf;
  assign unused_ovf = ovf;
`endif

  // ---------------------------------------------------------------------------
  // Conversion FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would infer a latch.
    state_d      = state_q;
    shift_d      = shift_q;
    bcd_d        = bcd_q;
    split_d      = split_q;
    cnt_d        = cnt_q;
    disp_d       = disp_q;
    disp_split_d = disp_split_q;
`ifdef ALU_RESULT_DISPLAY_OVF_EN
    ovf_lat_d    = ovf_lat_q;
    disp_ovf_d   = disp_ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (load) begin
          shift_d   = value;
          bcd_d     = '0;
          split_d   = (func == 2'b11);
          cnt_d     = (func == 2'b11) ? 4'(WIDTH) : 4'(RW);
`ifdef ALU_RESULT_DISPLAY_OVF_EN
          ovf_lat_d = ovf & ~func[1];
`endif
          state_d   = CONV;
        end
      end
      CONV: begin
        // One left shift of the whole source word serves both modes: the
        // quotient field reads bit RW-1 and the remainder field reads bit
        // WIDTH-1, and within WIDTH shifts neither sees the other's bits.
        shift_d = shift_q << 1;
        if (split_q)
          bcd_d = {bcd_adj[14:8], shift_q[RW-1], bcd_adj[6:0], shift_q[WIDTH-1]};
        else
          bcd_d = {bcd_adj[14:0], shift_q[RW-1]};
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = COMMIT;
      end
      COMMIT: begin
        disp_d       = bcd_q;
        disp_split_d = split_q;
`ifdef ALU_RESULT_DISPLAY_OVF_EN
        disp_ovf_d   = ovf_lat_q;
`endif
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Display scan. seg/an are registered from the *next* display contents so
  // new digits appear right after the commit edge.
  // ---------------------------------------------------------------------------
  logic [3:0] nib;
  logic       blank;

  always_comb begin
    if (presc_q == PW'(SCAN_DIV - 1)) begin
      presc_d = '0;
      idx_d   = idx_q + 2'd1;
    end else begin
      presc_d = presc_q + 1'b1;
      idx_d   = idx_q;
    end
    nib   = disp_d[{idx_d, 2'b00} +: 4];
    blank = 1'b0;
    if (!disp_split_d) begin
      unique case (idx_d)
        2'd3:    blank = (disp_d[15:12] == 4'd0);
        2'd2:    blank = (disp_d[15:8]  == 8'd0);
        2'd1:    blank = (disp_d[15:4]  == 12'd0);
        default: blank = 1'b0;
      endcase
    end
    seg_d = blank ? 7'b1111111 : seg_code(nib);
    an_d  = ~(4'b0001 << idx_d);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its inputs from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      bcd_q        <= '0;
      split_q      <= 1'b0;
      cnt_q        <= '0;
      disp_q       <= '0;
      disp_split_q <= 1'b0;
      presc_q      <= '0;
      idx_q        <= 2'd0;
      an_q         <= 4'b1110;
      seg_q        <= 7'b1000000;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bcd_q        <= bcd_d;
      split_q      <= split_d;
      cnt_q        <= cnt_d;
      disp_q       <= disp_d;
      disp_split_q <= disp_split_d;
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
    end
  end

`ifdef ALU_RESULT_DISPLAY_OVF_EN
  assign dp_d = ~(disp_ovf_d && (idx_d == 2'd3));

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_lat_q  <= 1'b0;
      disp_ovf_q <= 1'b0;
      dp_q       <= 1'b1;
    end else begin
      ovf_lat_q  <= ovf_lat_d;
      disp_ovf_q <= disp_ovf_d;
      dp_q       <= dp_d;
    end
  end

  assign dp = dp_q;
`else
  assign dp = 1'b1;
`endif

  assign busy = (state_q != IDLE);
  assign seg  = seg_q;
  assign an   = an_q;

endmodule

// File: tb/tb_alu_result_display.sv
// -----------------------------------------------------------------------------
// tb_alu_result_display
//
// Directed bench for alu_result_display with WIDTH = 6 and SCAN_DIV = 4.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_alu_result_display;

  localparam int WIDTH    = 6;
  localparam int SCAN_DIV = 4;

  localparam logic [6:0] S_BLANK = 7'b1111111;
  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S9 = 7'b0010000;

  logic               clk = 1'b0;
  logic               rst;
  logic               load;
  logic [2*WIDTH-1:0] value;
  logic [1:0]         func;
  logic               ovf;
  logic               busy;
  logic [6:0]         seg;
  logic               dp;
  logic [3:0]         an;

  int total = 0;
  int bad   = 0;

  alu_result_display #(.WIDTH(WIDTH), .SCAN_DIV(SCAN_DIV)) dut (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .value(value),
    .func (func),
    .ovf  (ovf),
    .busy (busy),
    .seg  (seg),
    .dp   (dp),
    .an   (an)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) until digit idx is selected, then compare its segments.
  task automatic check_digit(input string tag, input int idx, input logic [6:0] exp);
    logic [3:0] one;
    logic [3:0] pat;
    int n;
    one = 4'b0001;
    pat = ~(one << idx);
    n   = 0;
    while (an !== pat && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_an"}, an, pat);
    check(tag, seg, exp);
  endtask

  // Called on the falling edge right after the load edge; counts busy cycles.
  task automatic check_busy_len(input string tag, input int exp);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    check(tag, n, exp);
  endtask

  task automatic do_load(input logic [11:0] v, input logic [1:0] f, input logic o);
    @(negedge clk);
    value = v;
    func  = f;
    ovf   = o;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  initial begin
    int n;
    logic [3:0] pats [4];
    pats[0] = 4'b1110; pats[1] = 4'b1101; pats[2] = 4'b1011; pats[3] = 4'b0111;

    rst = 1'b1; load = 1'b0; value = '0; func = 2'b00; ovf = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_busy", busy, 1'b0);
    check("rst_an",   an,   4'b1110);
    check("rst_seg",  seg,  S0);
    check("rst_dp",   dp,   1'b1);
    rst = 1'b0;
    check_digit("rst_d1", 1, S_BLANK);
    check_digit("rst_d3", 3, S_BLANK);

    // 1: add, 7 -> "   7", busy 13 cycles
    do_load(12'd7, 2'b00, 1'b0);
    check_busy_len("t1_busy", 13);
    check_digit("t1_d0", 0, S7);
    check_digit("t1_d1", 1, S_BLANK);
    check_digit("t1_d2", 2, S_BLANK);
    check_digit("t1_d3", 3, S_BLANK);

    // 2: mul, 4095 -> "4095", scan order and hold time
    do_load(12'd4095, 2'b10, 1'b0);
    check_busy_len("t2_busy", 13);
    check_digit("t2_d3", 3, S4);
    check_digit("t2_d2", 2, S0);
    check_digit("t2_d1", 1, S9);
    check_digit("t2_d0", 0, S5);
    // align to the start of a full scan (an just moved off 0111)
    n = 0;
    while (an !== 4'b0111 && n < 40) begin @(negedge clk); n++; end
    while (an === 4'b0111 && n < 40) begin @(negedge clk); n++; end
    for (int p = 0; p < 4; p++) begin
      int h;
      h = 0;
      while (an === pats[p] && h < 10) begin @(negedge clk); h++; end
      check($sformatf("t2_hold%0d", p), h, 4);
    end

    // 3: div, q=63 r=5 -> "6305", busy 7 cycles, no blanking
    do_load({6'd63, 6'd5}, 2'b11, 1'b0);
    check_busy_len("t3_busy", 7);
    check_digit("t3_d3", 3, S6);
    check_digit("t3_d2", 2, S3);
    check_digit("t3_d1", 1, S0);
    check_digit("t3_d0", 0, S5);

    // 4: load 100, second load (200) during CONV cycle 3 is ignored
    do_load(12'd100, 2'b00, 1'b0);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      if (n == 3) begin value = 12'd200; load = 1'b1; end
      else load = 1'b0;
      @(negedge clk);
    end
    load = 1'b0;
    check("t4_busy", n, 13);
    check_digit("t4_d3", 3, S_BLANK);
    check_digit("t4_d2", 2, S1);
    check_digit("t4_d1", 1, S0);
    check_digit("t4_d0", 0, S0);

    // 5: reset at CONV cycle 5, then immediate new load of 55
    do_load(12'd1234, 2'b00, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t5_busy", busy, 1'b0);
    check("t5_an",   an,   4'b1110);
    check("t5_seg",  seg,  S0);
    check("t5_dp",   dp,   1'b1);
    rst   = 1'b0;
    value = 12'd55;
    func  = 2'b00;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    check_busy_len("t5_busy2", 13);
    check_digit("t5_d0", 0, S5);
    check_digit("t5_d1", 1, S5);
    check_digit("t5_d2", 2, S_BLANK);

    // 6: add with overflow, 40 -> "  40"; dp only on digit 3 when enabled
    do_load(12'd40, 2'b00, 1'b1);
    check_busy_len("t6_busy", 13);
    check_digit("t6_d1", 1, S4);
    check_digit("t6_d0", 0, S0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
`ifdef ALU_RESULT_DISPLAY_OVF_EN
      check($sformatf("t6_dp%0d", i), dp, (an === 4'b0111) ? 1'b0 : 1'b1);
`else
      check($sformatf("t6_dp%0d", i), dp, 1'b1);
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_result_display.md
Name: alu_result_display

Overview:
- Downstream consumer of the ALU result bus.
- Captures the result word, func code and overflow flag on a load strobe.
- Converts the result to BCD with a sequential double-dabble (shift-add-3) engine, then drives a 4-digit multiplexed, active-low 7-segment display.
- In divide mode (func = 11), the quotient and remainder are shown as two independent 2-digit fields.

Parameters:
- WIDTH, 6, ALU operand width; the result bus is 2*WIDTH bits. Legal range 2..6, so the full result fits in 4 decimal digits.
- SCAN_DIV, 50000, clock cycles per digit in the display scan (must be ≥ 2).

Ports:
- clk  input  1  system clock, all logic on its rising edge
- rst  input  1  synchronous, active-high reset
- load  input  1  capture strobe, sampled only in IDLE
- value  input  2*WIDTH  ALU result; in divide mode [2*WIDTH-1:WIDTH] = quotient, [WIDTH-1:0] = remainder
- func  input  2  ALU function code (00 add, 01 sub, 10 mul, 11 div)
- ovf  input  1  ALU overflow flag
- busy  output  1  high while a conversion is in progress
- seg  output  7  segment drive, active-low, bit order {g,f,e,d,c,b,a}
- dp  output  1  decimal point, active-low
- an  output  4  digit enables, active-low one-hot, an[3] = leftmost digit

Behaviour:
- Reset (rst high at a rising edge):
  - FSM → IDLE, busy = 0; shift/BCD registers and the display register cleared; prescaler = 0; digit index = 0.
  - Outputs: an = 1110, seg = 1000000 (digit "0"), dp = 1.
  - Display after reset: digit 0 shows "0", digits 3..1 blank.
  - Reset mid-conversion aborts it; the display is cleared as above.
- FSM states: IDLE, CONV, COMMIT.
- IDLE, load = 1:
  - Latch value, func, ovf.
  - Mode = SPLIT if func == 11, else FULL.
  - Shift count N = WIDTH in SPLIT, 2*WIDTH in FULL.
  - Go to CONV.
- CONV, one double-dabble iteration per clock:
  - FULL: one 4-digit BCD accumulator; add 3 to every nibble ≥ 5, then shift left, inserting the next MSB of value.
  - SPLIT: two independent 2-digit accumulators fed from quotient and remainder, shifted in parallel.
  - After N iterations go to COMMIT.
- COMMIT: copy the BCD result and mode to the display register in one cycle, then return to IDLE.
- Latency:
  - load sampled at edge k → CONV at edges k+1..k+N, COMMIT at k+N+1.
  - New digits are visible after edge k+N+1.
  - busy is high from edge k until edge k+N+1.
- load while busy is ignored and not queued. load held high re-triggers on the first cycle back in IDLE.
- Values are treated as unsigned; a negative sub result is shown as its unsigned magnitude.
- Blanking:
  - FULL: leading zeros blanked on digits 3..1; digit 0 always shown.
  - SPLIT: no blanking; the layout is [q tens][q ones][r tens][r ones].
  - A blank digit drives seg = 1111111.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1; on wrap, the digit index increments mod 4 (3 → 0).
  - an = active-low one-hot of the index; seg is registered from the selected digit in the same cycle as an.
  - The scan runs continuously, independent of the FSM; the display register changes only in COMMIT.
- Segment codes (gfedcba, active-low):

      0 = 1000000    1 = 1111001    2 = 0100100    3 = 0110000    4 = 0011001
      5 = 0010010    6 = 0000010    7 = 1111000    8 = 0000000    9 = 0010000

  BCD values > 9 cannot occur.

Optional Feature:
- Macro: ALU_RESULT_DISPLAY_OVF_EN.
- Defined:
  - The latched ovf is stored in the display register at COMMIT.
  - If it is 1 and func is 00 or 01, dp = 0 while digit 3 is selected; otherwise dp = 1.
- Undefined:
  - The ovf input is unused and dp is constant 1.
  - There is no ovf storage logic.

Test Plan:
1. WIDTH=6, func=00, value=7, pulse load → busy high exactly 13 cycles; digits show blank, blank, blank, "7" (digit 0 seg = 1111000, digits 3..1 seg = 1111111).
2. func=10, value=4095, load → after 13 cycles, digits 3..0 = 4, 0, 9, 5; SCAN_DIV=4 bench sees each an pattern held 4 cycles, order 1110 → 1101 → 1011 → 0111.
3. func=11, value={6'd63, 6'd5}, load → busy high 7 cycles; digits = 6, 3, 0, 5 with no blanking.
4. value=100 loaded, then load with value=200 pulsed at cycle 3 of CONV → second load ignored; display shows 100; busy drops on schedule.
5. Assert rst at cycle 5 of CONV → busy = 0 next cycle; display shows single "0"; an = 1110; FSM accepts a new load immediately.
6. ALU_RESULT_DISPLAY_OVF_EN defined, func=00, ovf=1, value=40, load → dp = 0 only while an = 0111. Macro undefined → dp = 1 always.
